// File: rtl/pic_bus_sequencer.sv
// -----------------------------------------------------------------------------
// pic_bus_sequencer
//
// CPU-bus front end of an 8259A-style interrupt controller. It samples the
// chip-select, write and read strobes synchronously and tracks the
// ICW1 -> ICW2 -> [ICW3] -> [ICW4] initialization sequence. Every accepted
// write is classified as ICWn or OCWn and handed to the control logic as a
// one-cycle command code together with the latched data byte. All outputs
// are registered.
//
// Ports
//   clk        in   system clock; all bus inputs are synchronous to it
//   rst_n      in   asynchronous active-low reset
//   cs_n       in   chip select, active-low
//   wr_n       in   write strobe, active-low; a write commits on its rising edge
//   rd_n       in   read strobe, active-low
//   a0         in   address bit A0
//   d_in[7:0]  in   CPU data bus
//   wr_cur[2:0] out command code (ICW1..OCW3 = 000..110, IDLE_CODE otherwise)
//   wr_valid   out  one-cycle strobe that accompanies a non-idle wr_cur
//   ds[7:0]    out  data byte of the last accepted write
//   rd_flag    out  registered read-active (cs_n=0 and rd_n=0)
//   rd_a0      out  A0 captured when a read becomes active (1 = IMR read)
//   sngl       out  ICW1 D1, latched
//   ic4        out  ICW1 D0, latched
//   init_done  out  high once the init sequence is complete
// -----------------------------------------------------------------------------
module pic_bus_sequencer #(
    // Code presented on wr_cur when no command is active. It lies outside the
    // ICW1..OCW3 range, so the downstream command decode ignores it.
    parameter logic [2:0] IDLE_CODE = 3'b111
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_n,
    input  logic       wr_n,
    input  logic       rd_n,
    input  logic       a0,
    input  logic [7:0] d_in,
    output logic [2:0] wr_cur,
    output logic       wr_valid,
    output logic [7:0] ds,
    output logic       rd_flag,
    output logic       rd_a0,
    output logic       sngl,
    output logic       ic4,
    output logic       init_done
);

    // Command codes on the wr_cur encoding.
    localparam logic [2:0] CODE_ICW1 = 3'b000;
    localparam logic [2:0] CODE_ICW2 = 3'b001;
    localparam logic [2:0] CODE_ICW3 = 3'b010;
    localparam logic [2:0] CODE_ICW4 = 3'b011;
    localparam logic [2:0] CODE_OCW1 = 3'b100;
    localparam logic [2:0] CODE_OCW2 = 3'b101;
    localparam logic [2:0] CODE_OCW3 = 3'b110;

    typedef enum logic [2:0] {
        UNINIT    = 3'd0,
        WAIT_ICW2 = 3'd1,
        WAIT_ICW3 = 3'd2,
        WAIT_ICW4 = 3'd3,
        READY     = 3'd4
    } state_e;

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    state_e     state_q,     state_d;
    logic       wr_armed_q,  wr_armed_d;
    logic       hold_a0_q,   hold_a0_d;
    logic [7:0] hold_d_q,    hold_d_d;
    logic [2:0] wr_cur_q,    wr_cur_d;
    logic       wr_valid_q,  wr_valid_d;
    logic [7:0] ds_q,        ds_d;
    logic       rd_flag_q,   rd_flag_d;
    logic       rd_a0_q,     rd_a0_d;
    logic       sngl_q,      sngl_d;
    logic       ic4_q,       ic4_d;
    logic       init_done_q, init_done_d;

    // Intermediate decode results.
    logic       commit;
    logic       accept;
    logic [2:0] cmd_code;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave a value unassigned and infer a latch.
        state_d     = state_q;
        wr_armed_d  = wr_armed_q;
        hold_a0_d   = hold_a0_q;
        hold_d_d    = hold_d_q;
        wr_cur_d    = IDLE_CODE;
        wr_valid_d  = 1'b0;
        ds_d        = ds_q;
        rd_flag_d   = ~cs_n & ~rd_n;
        rd_a0_d     = rd_a0_q;
        sngl_d      = sngl_q;
        ic4_d       = ic4_q;
        init_done_d = init_done_q;
        commit      = 1'b0;
        accept      = 1'b0;
        cmd_code    = IDLE_CODE;

        // Read path: A0 is captured only on the first active cycle, so a
        // change of A0 during a long read does not alter the selected register.
        if (rd_flag_d && !rd_flag_q) begin
            rd_a0_d = a0;
        end

        // Write path. While the strobe is low the bus is re-sampled every
        // cycle, so the last value before the rising edge is the one used.
        if (!cs_n && !wr_n) begin
            hold_a0_d  = a0;
            hold_d_d   = d_in;
            wr_armed_d = 1'b1;
        end else if (wr_armed_q && wr_n) begin
            // Rising edge of wr_n after a captured low phase.
            wr_armed_d = 1'b0;
            commit     = 1'b1;
        end else if (wr_armed_q && cs_n) begin
            // Chip select dropped with the strobe still low: write is lost.
            wr_armed_d = 1'b0;
        end

        // Classification of a committed write (held A0, D4, D3).
        if (commit) begin
            if (!hold_a0_q && hold_d_q[4]) begin
                // ICW1 is accepted in every state and restarts the sequence.
                accept      = 1'b1;
                cmd_code    = CODE_ICW1;
                sngl_d      = hold_d_q[1];
                ic4_d       = hold_d_q[0];
                init_done_d = 1'b0;
                state_d     = WAIT_ICW2;
            end else begin
                unique case (state_q)
                    WAIT_ICW2: begin
                        if (hold_a0_q) begin
                            accept   = 1'b1;
                            cmd_code = CODE_ICW2;
                            // sngl/ic4 come from the ICW1 already latched.
                            if (!sngl_q) begin
                                state_d = WAIT_ICW3;
                            end else if (ic4_q) begin
                                state_d = WAIT_ICW4;
                            end else begin
                                state_d     = READY;
                                init_done_d = 1'b1;
                            end
                        end
                    end
                    WAIT_ICW3: begin
                        if (hold_a0_q) begin
                            accept   = 1'b1;
                            cmd_code = CODE_ICW3;
                            if (ic4_q) begin
                                state_d = WAIT_ICW4;
                            end else begin
                                state_d     = READY;
                                init_done_d = 1'b1;
                            end
                        end
                    end
                    WAIT_ICW4: begin
                        if (hold_a0_q) begin
                            accept      = 1'b1;
                            cmd_code    = CODE_ICW4;
                            state_d     = READY;
                            init_done_d = 1'b1;
                        end
                    end
                    READY: begin
                        accept = 1'b1;
                        if (hold_a0_q) begin
                            cmd_code = CODE_OCW1;
                        end else if (hold_d_q[3]) begin
                            cmd_code = CODE_OCW3;
                        end else begin
                            cmd_code = CODE_OCW2;
                        end
                    end
                    default: begin
                        // UNINIT: anything other than ICW1 is ignored.
                        accept = 1'b0;
                    end
                endcase
            end
        end

        if (accept) begin
            wr_cur_d   = cmd_code;
            wr_valid_d = 1'b1;
            ds_d       = hold_d_q;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= UNINIT;
            wr_armed_q  <= 1'b0;
            hold_a0_q   <= 1'b0;
            hold_d_q    <= 8'h00;
            wr_cur_q    <= IDLE_CODE;
            wr_valid_q  <= 1'b0;
            ds_q        <= 8'h00;
            rd_flag_q   <= 1'b0;
            rd_a0_q     <= 1'b0;
            sngl_q      <= 1'b0;
            ic4_q       <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the
            // pre-edge value of the others, independent of statement order.
            state_q     <= state_d;
            wr_armed_q  <= wr_armed_d;
            hold_a0_q   <= hold_a0_d;
            hold_d_q    <= hold_d_d;
            wr_cur_q    <= wr_cur_d;
            wr_valid_q  <= wr_valid_d;
            ds_q        <= ds_d;
            rd_flag_q   <= rd_flag_d;
            rd_a0_q     <= rd_a0_d;
            sngl_q      <= sngl_d;
            ic4_q       <= ic4_d;
            init_done_q <= init_done_d;
        end
    end

    assign wr_cur    = wr_cur_q;
    assign wr_valid  = wr_valid_q;
    assign ds        = ds_q;
    assign rd_flag   = rd_flag_q;
    assign rd_a0     = rd_a0_q;
    assign sngl      = sngl_q;
    assign ic4       = ic4_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_pic_bus_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pic_bus_sequencer
//
// Directed bench for pic_bus_sequencer. Each bus write that should be accepted
// pushes its hand-computed response (code, data, init_done, sngl, ic4) into a
// queue; an independent monitor pops an entry whenever the DUT raises
// wr_valid and checks that wr_cur is idle on every other cycle.
// -----------------------------------------------------------------------------
module tb_pic_bus_sequencer;

    localparam logic [2:0] IDLE = 3'b111;

    typedef struct {
        logic [2:0] code;
        logic [7:0] data;
        logic       init_done;
        logic       sngl;
        logic       ic4;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       cs_n;
    logic       wr_n;
    logic       rd_n;
    logic       a0;
    logic [7:0] d_in;
    logic [2:0] wr_cur;
    logic       wr_valid;
    logic [7:0] ds;
    logic       rd_flag;
    logic       rd_a0;
    logic       sngl;
    logic       ic4;
    logic       init_done;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    pic_bus_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs_n      (cs_n),
        .wr_n      (wr_n),
        .rd_n      (rd_n),
        .a0        (a0),
        .d_in      (d_in),
        .wr_cur    (wr_cur),
        .wr_valid  (wr_valid),
        .ds        (ds),
        .rd_flag   (rd_flag),
        .rd_a0     (rd_a0),
        .sngl      (sngl),
        .ic4       (ic4),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_wr_cur"},    32'(wr_cur),    32'(IDLE));
        check({tag, "_wr_valid"},  32'(wr_valid),  0);
        check({tag, "_ds"},        32'(ds),        0);
        check({tag, "_rd_flag"},   32'(rd_flag),   0);
        check({tag, "_rd_a0"},     32'(rd_a0),     0);
        check({tag, "_sngl"},      32'(sngl),      0);
        check({tag, "_ic4"},       32'(ic4),       0);
        check({tag, "_init_done"}, 32'(init_done), 0);
    endtask

    task automatic expect_strobe(input logic [2:0] code, input logic [7:0] data,
                                 input logic idn, input logic sg, input logic c4);
        exp_t e;
        e.code      = code;
        e.data      = data;
        e.init_done = idn;
        e.sngl      = sg;
        e.ic4       = c4;
        exp_q.push_back(e);
    endtask

    // One-cycle write: strobe low for one cycle, then high; the commit edge
    // falls between the second and third negedge.
    task automatic bus_write(input logic addr, input logic [7:0] data);
        @(negedge clk);
        cs_n = 1'b0; wr_n = 1'b0; a0 = addr; d_in = data;
        @(negedge clk);
        wr_n = 1'b1; cs_n = 1'b1;
        @(negedge clk);
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (wr_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 32'(wr_valid), 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("strobe_code",      32'(wr_cur),    32'(e.code));
                check("strobe_ds",        32'(ds),        32'(e.data));
                check("strobe_init_done", 32'(init_done), 32'(e.init_done));
                check("strobe_sngl",      32'(sngl),      32'(e.sngl));
                check("strobe_ic4",       32'(ic4),       32'(e.ic4));
            end
        end else begin
            check("idle_code", 32'(wr_cur), 32'(IDLE));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1; a0 = 1'b0; d_in = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Ignored write in UNINIT.
        bus_write(1'b1, 8'hAA);
        @(negedge clk);
        check("uninit_ignore_ds", 32'(ds), 0);
        check("uninit_ignore_init_done", 32'(init_done), 0);

        // Single mode without ICW4, then OCW1.
        expect_strobe(3'b000, 8'h12, 1'b0, 1'b1, 1'b0);
        bus_write(1'b0, 8'h12);
        expect_strobe(3'b001, 8'h20, 1'b1, 1'b1, 1'b0);
        bus_write(1'b1, 8'h20);
        expect_strobe(3'b100, 8'hFB, 1'b1, 1'b1, 1'b0);
        bus_write(1'b1, 8'hFB);

        // OCW decode in READY; ICW1 restarts the sequence.
        expect_strobe(3'b101, 8'h20, 1'b1, 1'b1, 1'b0);
        bus_write(1'b0, 8'h20);
        expect_strobe(3'b110, 8'h0B, 1'b1, 1'b1, 1'b0);
        bus_write(1'b0, 8'h0B);
        expect_strobe(3'b000, 8'h13, 1'b0, 1'b1, 1'b1);
        bus_write(1'b0, 8'h13);

        // Cascade with ICW4, including an ignored write in WAIT_ICW3.
        expect_strobe(3'b000, 8'h11, 1'b0, 1'b0, 1'b1);
        bus_write(1'b0, 8'h11);
        expect_strobe(3'b001, 8'h08, 1'b0, 1'b0, 1'b1);
        bus_write(1'b1, 8'h08);
        bus_write(1'b0, 8'h20);
        check("icw3_ignore_ds", 32'(ds), 32'h08);
        expect_strobe(3'b010, 8'h04, 1'b0, 1'b0, 1'b1);
        bus_write(1'b1, 8'h04);
        expect_strobe(3'b011, 8'h01, 1'b1, 1'b0, 1'b1);
        bus_write(1'b1, 8'h01);

        // Aborted write: cs_n rises while wr_n is still low.
        @(negedge clk);
        cs_n = 1'b0; wr_n = 1'b0; a0 = 1'b1; d_in = 8'h55;
        @(negedge clk);
        cs_n = 1'b1;
        @(negedge clk);
        wr_n = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_ds", 32'(ds), 32'h01);

        // Read path: 3-cycle IMR read; A0 changes mid-read and must not stick.
        @(negedge clk);
        cs_n = 1'b0; rd_n = 1'b0; a0 = 1'b1;
        #1 check("rd_flag_latency", 32'(rd_flag), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rd_flag_active", 32'(rd_flag), 1);
            check("rd_a0_imr", 32'(rd_a0), 1);
            check("rd_wr_cur_idle", 32'(wr_cur), 32'(IDLE));
            a0 = 1'b0;
        end
        cs_n = 1'b1; rd_n = 1'b1;
        @(negedge clk);
        check("rd_flag_fall", 32'(rd_flag), 0);
        // Status read with A0=0.
        cs_n = 1'b0; rd_n = 1'b0; a0 = 1'b0;
        @(negedge clk);
        check("rd_a0_status", 32'(rd_a0), 0);
        cs_n = 1'b1; rd_n = 1'b1;
        @(negedge clk);

        // Reset in WAIT_ICW2 with a write pending.
        expect_strobe(3'b000, 8'h13, 1'b0, 1'b1, 1'b1);
        bus_write(1'b0, 8'h13);
        @(negedge clk);
        cs_n = 1'b0; wr_n = 1'b0; a0 = 1'b1; d_in = 8'h20;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_values("async_reset");
        @(negedge clk);
        wr_n = 1'b1; cs_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_values("after_reset");
        bus_write(1'b1, 8'h20);
        @(negedge clk);
        check("post_reset_ignore_ds", 32'(ds), 0);
        check("post_reset_ignore_init_done", 32'(init_done), 0);

        check("all_strobes_seen", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pic_bus_sequencer.md
# pic_bus_sequencer

Upstream CPU-bus front end of the 8259A-style PIC. It samples the CPU write/read strobes, tracks the ICW1→ICW2→[ICW3]→[ICW4] initialization sequence, and classifies every accepted write as ICWn/OCWn. It delivers one-cycle command codes plus latched data to the control logic on the existing `WR_cur`/`Ds`/`RD_flag` encoding. It is a clocked replacement for ad-hoc strobe decoding: all outputs are registered.

## Interface
- `IDLE_CODE`, 3'b111: `wr_cur` value when no command is being presented. It is outside the ICW1..OCW3 codes, so the control-logic `case` ignores it.
- `clk` in 1: system clock. All bus inputs are synchronous to it.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cs_n` in 1: chip select, active-low.
- `wr_n` in 1: write strobe, active-low. A write is committed on its rising edge.
- `rd_n` in 1: read strobe, active-low.
- `a0` in 1: address bit A0.
- `d_in` in 8: CPU data bus.
- `wr_cur` out 3: command code. ICW1=000, ICW2=001, ICW3=010, ICW4=011, OCW1=100, OCW2=101, OCW3=110, else `IDLE_CODE`.
- `wr_valid` out 1: one-cycle strobe, coincident with a non-idle `wr_cur`.
- `ds` out 8: data byte of the last accepted write. Held until the next accepted write.
- `rd_flag` out 1: registered read-active (cs_n=0 and rd_n=0).
- `rd_a0` out 1: A0 captured during the read. 1 = IMR read, 0 = status (IRR/ISR per OCW3).
- `sngl` out 1: ICW1 D1, latched.
- `ic4` out 1: ICW1 D0, latched.
- `init_done` out 1: high once the init sequence is complete.

## Operation
- The state machine has five states: UNINIT, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY. Reset enters UNINIT.
- **Write capture:** on every cycle with cs_n=0 and wr_n=0, register a0 and d_in into hold registers and set `wr_armed`.
- **Commit:** occurs on a cycle where `wr_armed`=1 and wr_n=1. The held values are classified and `wr_armed` is cleared.
- **Abort:** if cs_n rises while wr_n=0, clear `wr_armed`. The write is lost.
- **Classification:** applied to the held a0 and d (D4, D3):
  - a0=0, D4=1: ICW1 from any state. Latch `sngl`=D1 and `ic4`=D0, clear `init_done`, go to WAIT_ICW2. This restarts an in-progress sequence.
  - WAIT_ICW2, a0=1: ICW2. Next state is WAIT_ICW3 if `sngl`=0; otherwise WAIT_ICW4 if `ic4`=1; otherwise READY.
  - WAIT_ICW3, a0=1: ICW3. Next state is WAIT_ICW4 if `ic4`=1, else READY.
  - WAIT_ICW4, a0=1: ICW4, then READY.
  - READY, a0=1: OCW1.
  - READY, a0=0, D4=0, D3=0: OCW2.
  - READY, a0=0, D4=0, D3=1: OCW3.
  - UNINIT with anything but ICW1: ignored.
  - WAIT_* with a0=0 and D4=0: ignored. There is no strobe, and state, `ds` and `sngl`/`ic4` are unchanged.
- **Accepted write:** `wr_cur` gets the code, `wr_valid`=1, `ds` gets the held byte. On the next cycle `wr_cur` returns to `IDLE_CODE` and `wr_valid`=0, unless another commit occurs.
- **`init_done`:** set on entering READY, cleared by ICW1.
- **Reads:**
  - `rd_flag` follows (cs_n=0 and rd_n=0), registered.
  - `rd_a0` latches a0 on the cycle a read becomes active.
  - Reads are independent of the state machine and are legal in any state.
- **Simultaneous wr_n=0 and rd_n=0:** the write path operates normally and `rd_flag` still follows its equation. Resolving this bus conflict is the CPU's responsibility.

## Timing
- **Reset values:**
  - `wr_cur`=`IDLE_CODE`.
  - `wr_valid`, `ds`, `rd_flag`, `rd_a0`, `sngl`, `ic4`, `init_done` = 0.
  - State = UNINIT, `wr_armed`=0.
  - Reset is asynchronous, so outputs change immediately on rst_n falling, independent of clk.
- **Write latency:**
  - Edge k samples wr_n=1 with `wr_armed`=1.
  - `wr_cur`, `wr_valid` and `ds` are valid from edge k to edge k+1.
  - `wr_cur` is idle after edge k+1.
- **Minimum write:** wr_n low for 1 clock, with cs_n low during that cycle. Back-to-back writes with 1 high cycle between them produce adjacent strobes.
- **Read latency:** `rd_flag` rises 1 cycle after rd_n/cs_n go low and falls 1 cycle after either returns high.
- **Reset mid-write:** `wr_armed` is cleared, so the pending write is discarded when rst_n releases. The sequence restarts at UNINIT.
- **State transition** takes effect at the same edge that presents the command code.

## Test plan
- **Single mode, no ICW4:**
  - Stimulus: write (a0=0, 0x12), then (a0=1, 0x20).
  - Required response: codes 000 then 001, `sngl`=1, `ic4`=0, `init_done`=1.
  - Then write (a0=1, 0xFB): code 100 with `ds`=0xFB.
- **Cascade with ICW4:**
  - Stimulus: writes 0x11/a0=0, 0x08/a0=1, 0x04/a0=1, 0x01/a0=1.
  - Required response: codes 000, 001, 010, 011, each for exactly 1 cycle; `init_done` rises with the 011 strobe.
- **OCW decode in READY:**
  - (a0=0, 0x20) gives 101.
  - (a0=0, 0x0B) gives 110.
  - (a0=0, 0x13) gives 000, clears `init_done` and returns to WAIT_ICW2.
- **Ignored writes:**
  - After reset, write (a0=1, 0xAA): no `wr_valid`, `ds`=0x00.
  - In WAIT_ICW3, write (a0=0, 0x20): no strobe, state unchanged. A following (a0=1, 0x04) still yields 010.
- **Read path:**
  - Hold cs_n=0, rd_n=0, a0=1 for 3 cycles.
  - Required response: `rd_flag` high for 3 cycles starting 1 cycle late, `rd_a0`=1, `wr_cur` stays 111.
- **Reset mid-operation:**
  - Assert rst_n low while wr_n=0 in WAIT_ICW2, then release with wr_n high.
  - Required response: no strobe, all outputs at reset values, next ICW2-style write ignored.
